// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register: captures decoded control, operands and specifiers,
// with hazard stall/flush and a saturating debug count of inserted bubbles.
module id_ex_pipeline_register #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned REG_ADDR_WIDTH   = 5,
  parameter int unsigned BUBBLE_CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        id_valid,
  input  logic                        id_reg_write,
  input  logic                        id_mem_to_reg,
  input  logic                        id_mem_read,
  input  logic                        id_mem_write,
  input  logic                        id_branch,
  input  logic                        id_reg_dst,
  input  logic                        id_alu_src,
  input  logic [1:0]                  id_alu_op,
  input  logic [DATA_WIDTH-1:0]       id_pc_plus4,
  input  logic [DATA_WIDTH-1:0]       id_read_data1,
  input  logic [DATA_WIDTH-1:0]       id_read_data2,
  input  logic [DATA_WIDTH-1:0]       id_sign_ext_imm,
  input  logic [REG_ADDR_WIDTH-1:0]   id_rs,
  input  logic [REG_ADDR_WIDTH-1:0]   id_rt,
  input  logic [REG_ADDR_WIDTH-1:0]   id_rd,
  output logic                        ex_valid,
  output logic                        ex_reg_write,
  output logic                        ex_mem_to_reg,
  output logic                        ex_mem_read,
  output logic                        ex_mem_write,
  output logic                        ex_branch,
  output logic                        ex_reg_dst,
  output logic                        ex_alu_src,
  output logic [1:0]                  ex_alu_op,
  output logic [5:0]                  ex_funct,
  output logic [DATA_WIDTH-1:0]       ex_pc_plus4,
  output logic [DATA_WIDTH-1:0]       ex_read_data1,
  output logic [DATA_WIDTH-1:0]       ex_read_data2,
  output logic [DATA_WIDTH-1:0]       ex_sign_ext_imm,
  output logic [REG_ADDR_WIDTH-1:0]   ex_rs,
  output logic [REG_ADDR_WIDTH-1:0]   ex_rt,
  output logic [REG_ADDR_WIDTH-1:0]   ex_rd,
  output logic [BUBBLE_CNT_WIDTH-1:0] bubble_count
);

  localparam logic [BUBBLE_CNT_WIDTH-1:0] CNT_ONE = BUBBLE_CNT_WIDTH'(1);

  logic bubble_now;

  // A bubble enters EX on a flush, or on a normal load of a non-instruction.
  assign bubble_now = flush | (~stall & ~id_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid        <= 1'b0;
      ex_reg_write    <= 1'b0;
      ex_mem_to_reg   <= 1'b0;
      ex_mem_read     <= 1'b0;
      ex_mem_write    <= 1'b0;
      ex_branch       <= 1'b0;
      ex_reg_dst      <= 1'b0;
      ex_alu_src      <= 1'b0;
      ex_alu_op       <= '0;
      ex_funct        <= '0;
      ex_pc_plus4     <= '0;
      ex_read_data1   <= '0;
      ex_read_data2   <= '0;
      ex_sign_ext_imm <= '0;
      ex_rs           <= '0;
      ex_rt           <= '0;
      ex_rd           <= '0;
    end else if (flush) begin
      ex_valid        <= 1'b0;
      ex_reg_write    <= 1'b0;
      ex_mem_to_reg   <= 1'b0;
      ex_mem_read     <= 1'b0;
      ex_mem_write    <= 1'b0;
      ex_branch       <= 1'b0;
      ex_reg_dst      <= 1'b0;
      ex_alu_src      <= 1'b0;
      ex_alu_op       <= '0;
      ex_funct        <= '0;
      ex_pc_plus4     <= '0;
      ex_read_data1   <= '0;
      ex_read_data2   <= '0;
      ex_sign_ext_imm <= '0;
      ex_rs           <= '0;
      ex_rt           <= '0;
      ex_rd           <= '0;
    end else if (!stall) begin
      // Control is gated by id_valid; data fields load regardless.
      ex_valid        <= id_valid;
      ex_reg_write    <= id_valid & id_reg_write;
      ex_mem_to_reg   <= id_valid & id_mem_to_reg;
      ex_mem_read     <= id_valid & id_mem_read;
      ex_mem_write    <= id_valid & id_mem_write;
      ex_branch       <= id_valid & id_branch;
      ex_reg_dst      <= id_valid & id_reg_dst;
      ex_alu_src      <= id_valid & id_alu_src;
      ex_alu_op       <= id_valid ? id_alu_op : 2'b00;
      ex_funct        <= id_sign_ext_imm[5:0];
      ex_pc_plus4     <= id_pc_plus4;
      ex_read_data1   <= id_read_data1;
      ex_read_data2   <= id_read_data2;
      ex_sign_ext_imm <= id_sign_ext_imm;
      ex_rs           <= id_rs;
      ex_rt           <= id_rt;
      ex_rd           <= id_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count <= '0;
    end else if (bubble_now && (bubble_count != '1)) begin
      bubble_count <= bubble_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Directed + randomised scoreboard bench for id_ex_pipeline_register,
// run with a 4-bit bubble counter so saturation is reachable.
module tb_id_ex_pipeline_register;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        reg_dst;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [3:0]  bcnt;
  } ex_t;

  logic clk = 1'b0;
  logic rst_n, stall, flush, id_valid;
  logic id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write;
  logic id_branch, id_reg_dst, id_alu_src;
  logic [1:0]  id_alu_op;
  logic [31:0] id_pc_plus4, id_read_data1, id_read_data2, id_sign_ext_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
  logic ex_branch, ex_reg_dst, ex_alu_src;
  logic [1:0]  ex_alu_op;
  logic [5:0]  ex_funct;
  logic [31:0] ex_pc_plus4, ex_read_data1, ex_read_data2, ex_sign_ext_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [3:0]  bubble_count;

  ex_t obs;
  ex_t model;
  ex_t sb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  id_ex_pipeline_register #(
    .DATA_WIDTH(32),
    .REG_ADDR_WIDTH(5),
    .BUBBLE_CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_branch(id_branch), .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src),
    .id_alu_op(id_alu_op), .id_pc_plus4(id_pc_plus4),
    .id_read_data1(id_read_data1), .id_read_data2(id_read_data2),
    .id_sign_ext_imm(id_sign_ext_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .ex_funct(ex_funct), .ex_pc_plus4(ex_pc_plus4), .ex_read_data1(ex_read_data1),
    .ex_read_data2(ex_read_data2), .ex_sign_ext_imm(ex_sign_ext_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .bubble_count(bubble_count)
  );

  assign obs = {ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
                ex_branch, ex_reg_dst, ex_alu_src, ex_alu_op, ex_funct,
                ex_pc_plus4, ex_read_data1, ex_read_data2, ex_sign_ext_imm,
                ex_rs, ex_rt, ex_rd, bubble_count};

  task automatic check(input string tag, input ex_t e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic set_id(input logic v, input logic [6:0] ctl, input logic [1:0] aop,
                        input logic [31:0] pc, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] imm,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_valid = v;
    {id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
     id_branch, id_reg_dst, id_alu_src} = ctl;
    id_alu_op = aop; id_pc_plus4 = pc; id_read_data1 = d1; id_read_data2 = d2;
    id_sign_ext_imm = imm; id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  // Reference behaviour of one clock edge: flush > stall > load.
  task automatic step(input string tag, input logic f, input logic s);
    logic bub;
    flush = f; stall = s;
    bub = f | (~s & ~id_valid);
    if (f) begin
      model = '{bcnt: model.bcnt, default: '0};
    end else if (!s) begin
      model.valid      = id_valid;
      model.reg_write  = id_valid && id_reg_write;
      model.mem_to_reg = id_valid && id_mem_to_reg;
      model.mem_read   = id_valid && id_mem_read;
      model.mem_write  = id_valid && id_mem_write;
      model.branch     = id_valid && id_branch;
      model.reg_dst    = id_valid && id_reg_dst;
      model.alu_src    = id_valid && id_alu_src;
      model.alu_op     = id_valid ? id_alu_op : 2'b00;
      model.funct      = id_sign_ext_imm[5:0];
      model.pc  = id_pc_plus4;   model.rd1 = id_read_data1;
      model.rd2 = id_read_data2; model.imm = id_sign_ext_imm;
      model.rs = id_rs; model.rt = id_rt; model.rd = id_rd;
    end
    if (bub && model.bcnt != 4'hF) model.bcnt = model.bcnt + 4'd1;
    sb.push_back(model);
    @(posedge clk); #1;
    check(tag, sb.pop_front());
  endtask

  // Asynchronous reset pulse placed mid-cycle, checked before any clock edge.
  task automatic mid_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model = '0;
    sb.delete();
    check(tag, model);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; stall = 1'b0;
    set_id(1'b1, 7'h7F, 2'b11, 32'h11111111, 32'h22222222, 32'h33333333,
           32'h4444443F, 5'd1, 5'd2, 5'd3);
    model = '0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    // Fill the pipeline with nonzero contents, then reset mid-cycle.
    step("preload", 1'b0, 1'b0);
    mid_reset("reset_clears");

    // R-type add then sub: funct follows the immediate's low bits.
    set_id(1'b1, 7'b1000010, 2'b10, 32'h00400004, 32'h00000007, 32'h00000009,
           32'h00000020, 5'd1, 5'd2, 5'd5);
    step("rtype_add", 1'b0, 1'b0);
    set_id(1'b1, 7'b1000010, 2'b10, 32'h00400008, 32'h0000000A, 32'h00000003,
           32'h00000022, 5'd3, 5'd4, 5'd6);
    step("rtype_sub", 1'b0, 1'b0);

    // beq held across three stalls while decode inputs change.
    set_id(1'b1, 7'b0000100, 2'b01, 32'h0040000C, 32'h00000001, 32'h00000001,
           32'h00000010, 5'd7, 5'd8, 5'd0);
    step("beq_load", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 7'b1111111, 2'b10, $urandom, $urandom, $urandom, $urandom,
             5'd9, 5'd10, 5'd11);
      step("beq_stall", 1'b0, 1'b1);
    end

    // lw loaded, then flush with stall also asserted.
    set_id(1'b1, 7'b1110001, 2'b00, 32'h00400010, 32'h00001000, 32'h0,
           32'h00000004, 5'd12, 5'd13, 5'd0);
    step("lw_load", 1'b0, 1'b0);
    step("flush_over_stall", 1'b1, 1'b1);

    // Non-instruction load: control cleared, data still captured.
    set_id(1'b0, 7'b1000000, 2'b10, 32'h00400014, 32'hDEADBEEF, 32'hCAFEF00D,
           32'h0000002A, 5'd14, 5'd15, 5'd16);
    step("invalid_load", 1'b0, 1'b0);
    step("invalid_stall", 1'b0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      set_id(1'($urandom_range(0, 3) != 0), 7'($urandom), 2'($urandom), $urandom,
             $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
      step("random", 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) == 0));
    end

    // Reset while stalled, then first edge after release loads normally.
    set_id(1'b1, 7'b0001001, 2'b00, 32'h00400018, 32'h00002000, 32'h00000055,
           32'h00000008, 5'd17, 5'd18, 5'd19);
    stall = 1'b1;
    mid_reset("reset_mid_stall");
    step("post_reset_load", 1'b0, 1'b0);

    // Counter saturates at 15 and stays there.
    for (int i = 0; i < 20; i++) step("saturate", 1'b1, 1'b0);
    set_id(1'b0, 7'h00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    step("saturate_invalid", 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_pipeline_register.md
Name: id_ex_pipeline_register

Overview:
Decode-to-execute pipeline register for the MIPS 5-stage pipeline. It captures the decoded control bits, the register operands, the immediate, the register addresses and the funct field once per cycle. It presents them to the execution stage, where ALUOp/funct drive execution_alu_control and the operands drive the ALU. It supports hazard-unit stall (hold) and flush (bubble insert), and keeps a saturating count of inserted bubbles for debug.

Parameters:
DATA_WIDTH, 32, width of operands, PC+4 and immediate
REG_ADDR_WIDTH, 5, width of rs/rt/rd fields
BUBBLE_CNT_WIDTH, 16, width of saturating bubble counter

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hazard unit: hold current contents
flush  in  1  hazard/branch unit: load bubble (NOP)
id_valid  in  1  decode stage holds a real instruction
id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_reg_dst, id_alu_src  in  1 each  decoded control bits
id_alu_op  in  2  ALUOp from main control (00 add, 01 sub/beq, 10 R-type)
id_pc_plus4, id_read_data1, id_read_data2, id_sign_ext_imm  in  DATA_WIDTH each  decode-stage values
id_rs, id_rt, id_rd  in  REG_ADDR_WIDTH each  register specifiers
ex_valid  out  1  execute stage holds a real instruction
ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_reg_dst, ex_alu_src  out  1 each  registered control bits
ex_alu_op  out  2  registered ALUOp to execution_alu_control
ex_funct  out  6  registered id_sign_ext_imm[5:0] to execution_alu_control
ex_pc_plus4, ex_read_data1, ex_read_data2, ex_sign_ext_imm  out  DATA_WIDTH each  registered values
ex_rs, ex_rt, ex_rd  out  REG_ADDR_WIDTH each  registered specifiers (forwarding, RegDst mux)
bubble_count  out  BUBBLE_CNT_WIDTH  number of bubbles inserted since reset, saturating

Behaviour:
- Reset (rst_n low, asynchronous, no clock required): every output = 0. Control zero = bubble, so ALUOp 00 and funct 000000 reach the ALU control harmlessly.
- Latency: 1 cycle. Inputs sampled at rising edge N appear on outputs after edge N and hold until the next update.
- Per rising edge, priority flush > stall > load:
  - flush=1: ex_valid and all control outputs (reg_write, mem_to_reg, mem_read, mem_write, branch, reg_dst, alu_src, alu_op) := 0. Data, address and funct outputs := 0. Applies even if stall=1.
  - flush=0, stall=1: all outputs hold. bubble_count unchanged.
  - flush=0, stall=0: all fields load from id_* inputs. If id_valid=0, control bits and ex_valid load 0 but data fields still load.
- bubble_count increments by 1 on an edge where flush=1, or where (stall=0 and id_valid=0). It saturates at all-ones and never wraps. Only reset clears it.
- ex_funct is the low 6 bits of the immediate, loaded together with id_sign_ext_imm. It is not a separate input.
- No combinational path from any input to any output.
- Reset asserted mid-stall or mid-flush: outputs clear immediately. First edge after rst_n deasserts behaves normally.
- rst_n deassertion is synchronised externally. The block assumes clean release.

Test Plan:
- Reset: drive all id_* nonzero, pulse rst_n low mid-cycle -> all outputs 0 immediately, bubble_count=0.
- R-type add: id_valid=1, id_alu_op=10, id_sign_ext_imm=0x00000020, id_reg_write=1, id_reg_dst=1, rd=5 -> after 1 edge ex_alu_op=10, ex_funct=100000, ex_rd=5, ex_valid=1. Next instruction with imm 0x00000022 -> ex_funct=100010.
- Stall: load beq (alu_op=01, branch=1), then stall=1 for 3 edges while inputs change -> outputs remain alu_op=01, branch=1. bubble_count unchanged.
- Flush and simultaneous flush+stall: valid lw loaded, then flush=1 with stall=1 -> ex_valid=0, ex_mem_read=0, ex_alu_op=00, bubble_count +1.
- id_valid=0 load: id_reg_write=1 but id_valid=0, read_data1=0xDEADBEEF -> ex_reg_write=0, ex_valid=0, ex_read_data1=0xDEADBEEF, bubble_count +1.
- Saturation: with BUBBLE_CNT_WIDTH=4, assert flush for 20 edges -> bubble_count stops at 15.
